conv_add_tree_acc: RTL and testbench



---
 rtl/conv_pkg.sv | 70 +++++++
 rtl/add_tree_level.sv | 79 +++++++
 rtl/conv_add_tree_acc.sv | 190 +++++++++++++++++++
 tb/tb_conv_add_tree_acc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared helpers for the convolution datapath. It provides
//                the ceiling log2, the adder-tree and accumulator width
//                helpers, the per-level element count, the sign/zero fill
//                helper and the saturation limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Saturation limits are returned in a fixed-width container and then
    // sliced down to the accumulator width by the user.
    localparam int c_SAT_BITS = 64;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int tree_width(input int num, input int in_w);
        return in_w + clog2(num);
    endfunction

    function automatic int acc_width(input int num, input int in_w, input int extra);
        return tree_width(num, in_w) + extra;
    endfunction

    // Number of elements entering tree level 'lvl' (level 0 sees all NUM).
    function automatic int level_count(input int num, input int lvl);
        int n;
        n = num;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // Fill bit used when widening a value: its MSB for two's complement,
    // zero for unsigned.
    function automatic logic ext_fill(input logic msb, input bit is_signed);
        return is_signed ? msb : 1'b0;
    endfunction

    function automatic logic [c_SAT_BITS-1:0] sat_max(input int w, input bit is_signed);
        logic [c_SAT_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < c_SAT_BITS; i++) begin
            if (i < w) r[i] = 1'b1;
        end
        if (is_signed) r[w-1] = 1'b0;
        return r;
    endfunction

    function automatic logic [c_SAT_BITS-1:0] sat_min(input int w, input bit is_signed);
        logic [c_SAT_BITS-1:0] r;
        r = '0;
        if (is_signed) r[w-1] = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_tree_level.sv
`default_nettype none
// ============================================================================
//  Module      : add_tree_level
//  Description : One registered level of the pairwise adder tree. Adjacent
//                elements are summed into results one bit wider; an odd
//                leftover element is widened and passed through. Valid and
//                last are registered alongside the data.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid, in_last   - beat qualifiers entering the level
//                in_data             - N_IN elements of W_IN bits
//                out_valid, out_last - qualifiers one cycle later
//                out_data            - ceil(N_IN/2) elements of W_IN+1 bits
//  Revision    : 1.0 - initial release
// ============================================================================
module add_tree_level
    import conv_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int W_IN   = 8,
    parameter int SIGNED = 1
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    input  logic [N_IN*W_IN-1:0]                 in_data,
    output logic                                 out_valid,
    output logic                                 out_last,
    output logic [((N_IN+1)/2)*(W_IN+1)-1:0]     out_data
);

    localparam int c_N_OUT  = (N_IN + 1) / 2;
    localparam int c_W_OUT  = W_IN + 1;
    localparam bit c_SIGNED = (SIGNED != 0);

    logic [c_N_OUT*c_W_OUT-1:0] w_sum;
    logic [c_N_OUT*c_W_OUT-1:0] r_data;
    logic                       r_valid;
    logic                       r_last;

    for (genvar i = 0; i < c_N_OUT; i++) begin : g_pair
        logic [W_IN-1:0]    w_a;
        logic [c_W_OUT-1:0] w_a_ext;
        assign w_a     = in_data[2*i*W_IN +: W_IN];
        assign w_a_ext = {ext_fill(w_a[W_IN-1], c_SIGNED), w_a};

        if (2*i + 1 < N_IN) begin : g_add
            logic [W_IN-1:0]    w_b;
            logic [c_W_OUT-1:0] w_b_ext;
            assign w_b     = in_data[(2*i+1)*W_IN +: W_IN];
            assign w_b_ext = {ext_fill(w_b[W_IN-1], c_SIGNED), w_b};
            // One extra bit is always enough for the sum of two operands.
            assign w_sum[i*c_W_OUT +: c_W_OUT] = w_a_ext + w_b_ext;
        end else begin : g_pass
            assign w_sum[i*c_W_OUT +: c_W_OUT] = w_a_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            r_last  <= in_last;
        end
    end

    // Data is qualified by valid downstream, so it needs no reset.
    always_ff @(posedge clk) begin
        r_data <= w_sum;
    end

    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/conv_add_tree_acc.sv
`default_nettype none
// ============================================================================
//  Module      : conv_add_tree_acc
//  Description : Pipelined adder tree with multi-beat accumulation. Each
//                beat of NUM products is summed by a registered binary tree
//                and the tree sums of one pixel are accumulated until the
//                beat flagged last, with optional saturation on overflow.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                in_valid  - beat present this cycle
//                in_data   - NUM operands of IN_WIDTH bits, operand 0 in LSBs
//                in_last   - final beat of the pixel (qualified by in_valid)
//                out_valid - one-cycle pulse per completed pixel
//                out_data  - accumulated pixel sum, held between pulses
//                out_ovf   - accumulator overflowed during this pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_add_tree_acc
    import conv_pkg::*;
#(
    parameter int NUM       = 9,
    parameter int IN_WIDTH  = 8,
    parameter int SIGNED    = 1,
    parameter int ACC_EXTRA = 8,
    parameter int SATURATE  = 1
)(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    input  logic [NUM*IN_WIDTH-1:0]                       in_data,
    input  logic                                          in_last,
    output logic                                          out_valid,
    output logic [acc_width(NUM, IN_WIDTH, ACC_EXTRA)-1:0] out_data,
    output logic                                          out_ovf
);

    localparam int c_LEVELS   = clog2(NUM);
    localparam int c_TREE_W   = tree_width(NUM, IN_WIDTH);
    localparam int c_ACC_W    = acc_width(NUM, IN_WIDTH, ACC_EXTRA);
    localparam bit c_SIGNED   = (SIGNED != 0);
    localparam bit c_SATURATE = (SATURATE != 0);

    localparam logic [c_SAT_BITS-1:0] c_SAT_MAX_FULL = sat_max(c_ACC_W, c_SIGNED);
    localparam logic [c_SAT_BITS-1:0] c_SAT_MIN_FULL = sat_min(c_ACC_W, c_SIGNED);
    localparam logic [c_ACC_W-1:0]    c_SAT_MAX      = c_SAT_MAX_FULL[c_ACC_W-1:0];
    localparam logic [c_ACC_W-1:0]    c_SAT_MIN      = c_SAT_MIN_FULL[c_ACC_W-1:0];

    // ---------------------------------------------------------------- stage 0
    logic [NUM*IN_WIDTH-1:0] r_s0_data;
    logic                    r_s0_valid;
    logic                    r_s0_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
        end else begin
            r_s0_valid <= in_valid;
            // A last flag on an idle cycle must never reach the accumulator.
            r_s0_last  <= in_valid & in_last;
        end
    end

    always_ff @(posedge clk) begin
        r_s0_data <= in_data;
    end

    // ------------------------------------------------------------- adder tree
    logic [c_TREE_W-1:0] w_tree;
    logic                w_tree_valid;
    logic                w_tree_last;

    if (c_LEVELS == 0) begin : g_no_tree
        assign w_tree       = r_s0_data;
        assign w_tree_valid = r_s0_valid;
        assign w_tree_last  = r_s0_last;
    end else begin : g_tree
        for (genvar l = 0; l < c_LEVELS; l++) begin : g_lvl
            localparam int c_N_IN  = level_count(NUM, l);
            localparam int c_W_IN  = IN_WIDTH + l;
            localparam int c_N_OUT = (c_N_IN + 1) / 2;

            logic [c_N_IN*c_W_IN-1:0]      w_din;
            logic                          w_vin;
            logic                          w_lin;
            logic [c_N_OUT*(c_W_IN+1)-1:0] w_dout;
            logic                          w_vout;
            logic                          w_lout;

            if (l == 0) begin : g_src_stage0
                assign w_din = r_s0_data;
                assign w_vin = r_s0_valid;
                assign w_lin = r_s0_last;
            end else begin : g_src_level
                assign w_din = g_lvl[l-1].w_dout;
                assign w_vin = g_lvl[l-1].w_vout;
                assign w_lin = g_lvl[l-1].w_lout;
            end

            add_tree_level #(
                .N_IN   (c_N_IN),
                .W_IN   (c_W_IN),
                .SIGNED (SIGNED)
            ) u_level (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (w_vin),
                .in_last   (w_lin),
                .in_data   (w_din),
                .out_valid (w_vout),
                .out_last  (w_lout),
                .out_data  (w_dout)
            );
        end

        // The final level holds exactly one element of TREE_W bits.
        assign w_tree       = g_lvl[c_LEVELS-1].w_dout;
        assign w_tree_valid = g_lvl[c_LEVELS-1].w_vout;
        assign w_tree_last  = g_lvl[c_LEVELS-1].w_lout;
    end

    // ------------------------------------------------------------ accumulator
    logic [c_ACC_W-1:0] r_acc;
    logic               r_open;
    logic               r_ovf;
    logic               r_out_valid;
    logic [c_ACC_W-1:0] r_out_data;
    logic               r_out_ovf;

    logic               w_fill_t;
    logic [c_ACC_W-1:0] w_tree_ext;
    logic [c_ACC_W:0]   w_sum;
    logic               w_add_ovf;
    logic [c_ACC_W-1:0] w_acc_next;
    logic               w_ovf_next;

    always_comb begin
        w_fill_t   = ext_fill(w_tree[c_TREE_W-1], c_SIGNED);
        w_tree_ext = {c_ACC_W{w_fill_t}};
        w_tree_ext[c_TREE_W-1:0] = w_tree;

        // One guard bit above ACC_W exposes the true result of the add.
        w_sum = {ext_fill(r_acc[c_ACC_W-1], c_SIGNED), r_acc}
              + {w_fill_t, w_tree_ext};
        w_add_ovf = c_SIGNED ? (w_sum[c_ACC_W] ^ w_sum[c_ACC_W-1])
                             : w_sum[c_ACC_W];

        w_acc_next = w_tree_ext;
        w_ovf_next = 1'b0;
        if (r_open) begin
            w_ovf_next = r_ovf | w_add_ovf;
            if (w_add_ovf && c_SATURATE) begin
                // Guard bit is the true sign: negative overflow clamps low.
                w_acc_next = (c_SIGNED && w_sum[c_ACC_W]) ? c_SAT_MIN : c_SAT_MAX;
            end else begin
                w_acc_next = w_sum[c_ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_open      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_tree_valid) begin
                r_acc <= w_acc_next;
                r_ovf <= w_ovf_next;
                if (w_tree_last) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_acc_next;
                    r_out_ovf   <= w_ovf_next;
                    r_open      <= 1'b0;
                end else begin
                    r_open      <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_conv_add_tree_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_add_tree_acc
//  Description : Self-checking bench for conv_add_tree_acc. Six builds share
//                one stimulus stream; a behavioural pixel model predicts the
//                pulse cycle, sum and overflow flag for each build, and a set
//                of hand-computed expectations pins the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_add_tree_acc;

    localparam int c_ND   = 6;
    localparam int c_MAXC = 4096;

    // Build table: NUM, SIGNED, ACC_W, SATURATE, latency
    int p_num [c_ND] = '{9, 9, 9, 9, 1, 5};
    int p_sgn [c_ND] = '{1, 1, 1, 0, 1, 1};
    int p_accw[c_ND] = '{16, 8, 8, 10, 6, 9};
    int p_sat [c_ND] = '{1, 1, 0, 1, 1, 0};
    int p_lat [c_ND] = '{6, 6, 6, 6, 2, 5};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [35:0] ops = '0;
    int          cyc = 0;

    logic        ov0, ov1, ov2, ov3, ov4, ov5;
    logic        oo0, oo1, oo2, oo3, oo4, oo5;
    logic [15:0] od0;
    logic [7:0]  od1, od2;
    logic [9:0]  od3;
    logic [5:0]  od4;
    logic [8:0]  od5;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_add_tree_acc #(.NUM(9), .IN_WIDTH(4), .SIGNED(1), .ACC_EXTRA(8), .SATURATE(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(ops), .in_last(in_last),
        .out_valid(ov0), .out_data(od0), .out_ovf(oo0));
    conv_add_tree_acc #(.NUM(9), .IN_WIDTH(4), .SIGNED(1), .ACC_EXTRA(0), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(ops), .in_last(in_last),
        .out_valid(ov1), .out_data(od1), .out_ovf(oo1));
    conv_add_tree_acc #(.NUM(9), .IN_WIDTH(4), .SIGNED(1), .ACC_EXTRA(0), .SATURATE(0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(ops), .in_last(in_last),
        .out_valid(ov2), .out_data(od2), .out_ovf(oo2));
    conv_add_tree_acc #(.NUM(9), .IN_WIDTH(4), .SIGNED(0), .ACC_EXTRA(2), .SATURATE(1)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(ops), .in_last(in_last),
        .out_valid(ov3), .out_data(od3), .out_ovf(oo3));
    conv_add_tree_acc #(.NUM(1), .IN_WIDTH(4), .SIGNED(1), .ACC_EXTRA(2), .SATURATE(1)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(ops[3:0]), .in_last(in_last),
        .out_valid(ov4), .out_data(od4), .out_ovf(oo4));
    conv_add_tree_acc #(.NUM(5), .IN_WIDTH(4), .SIGNED(1), .ACC_EXTRA(2), .SATURATE(0)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(ops[19:0]), .in_last(in_last),
        .out_valid(ov5), .out_data(od5), .out_ovf(oo5));

    // ------------------------------------------------------------------ model
    bit     m_open[c_ND];
    longint m_acc [c_ND];
    bit     m_ovf [c_ND];
    bit     ev[c_ND][c_MAXC];
    longint ed[c_ND][c_MAXC];
    bit     eo[c_ND][c_MAXC];
    bit     rst_at[c_MAXC];

    typedef struct {
        int          d;
        int          c;
        bit          v;
        logic [63:0] data;
        bit          o;
        bit          cd;
    } lit_t;
    lit_t lits[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void model_beat(input int d, input bit last, input logic [35:0] o, input int c);
        longint s, lo, hi, m;
        logic [3:0] b;
        s = 0;
        for (int i = 0; i < p_num[d]; i++) begin
            b = o[4*i +: 4];
            s += (p_sgn[d] != 0) ? longint'($signed(b)) : longint'(b);
        end
        m  = longint'(1) << p_accw[d];
        lo = (p_sgn[d] != 0) ? -(m / 2) : 0;
        hi = (p_sgn[d] != 0) ? (m / 2 - 1) : (m - 1);
        if (!m_open[d]) begin
            m_acc[d] = s;
            m_ovf[d] = 1'b0;
        end else begin
            m_acc[d] += s;
            if (m_acc[d] > hi || m_acc[d] < lo) begin
                m_ovf[d] = 1'b1;
                if (p_sat[d] != 0) m_acc[d] = (m_acc[d] > hi) ? hi : lo;
                else               m_acc[d] = (((m_acc[d] - lo) % m) + m) % m + lo;
            end
        end
        if (last) begin
            if (c + p_lat[d] < c_MAXC) begin
                ev[d][c + p_lat[d]] = 1'b1;
                ed[d][c + p_lat[d]] = m_acc[d];
                eo[d][c + p_lat[d]] = m_ovf[d];
            end
            m_open[d] = 1'b0;
        end else begin
            m_open[d] = 1'b1;
        end
    endfunction

    task automatic step(input bit r, input bit v, input bit l, input logic [35:0] o);
        rst = r; in_valid = v; in_last = l; ops = o;
        rst_at[cyc] = r;
        if (r) begin
            for (int d = 0; d < c_ND; d++) begin
                m_open[d] = 1'b0;
                m_ovf[d]  = 1'b0;
                for (int c = cyc + 1; c < c_MAXC; c++) ev[d][c] = 1'b0;
            end
        end else if (v) begin
            for (int d = 0; d < c_ND; d++) model_beat(d, l, o, cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 36'h0);
    endtask

    task automatic add_lit(input int d, input int c, input bit v, input logic [63:0] data, input bit o, input bit cd);
        lit_t t;
        t.d = d; t.c = c; t.v = v; t.data = data; t.o = o; t.cd = cd;
        lits.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // -------------------------------------------------------------- compare
    logic        gv[c_ND];
    logic [63:0] gd[c_ND];
    logic        go[c_ND];
    logic [63:0] hd[c_ND];
    bit          ho[c_ND];

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < c_MAXC) begin
            gv = '{ov0, ov1, ov2, ov3, ov4, ov5};
            go = '{oo0, oo1, oo2, oo3, oo4, oo5};
            gd = '{64'(od0), 64'(od1), 64'(od2), 64'(od3), 64'(od4), 64'(od5)};
            for (int d = 0; d < c_ND; d++) begin
                if (rst_at[cyc-1]) begin
                    hd[d] = '0;
                    ho[d] = 1'b0;
                end
                if (ev[d][cyc]) begin
                    hd[d] = 64'(ed[d][cyc]) & ((64'd1 << p_accw[d]) - 64'd1);
                    ho[d] = eo[d][cyc];
                end
                chk($sformatf("valid d%0d c%0d", d, cyc), 64'(gv[d]), 64'(ev[d][cyc]));
                chk($sformatf("data d%0d c%0d", d, cyc), gd[d], hd[d]);
                chk($sformatf("ovf d%0d c%0d", d, cyc), 64'(go[d]), 64'(ho[d]));
            end
            foreach (lits[k]) begin
                if (lits[k].c == cyc) begin
                    chk($sformatf("lit valid d%0d c%0d", lits[k].d, cyc), 64'(gv[lits[k].d]), 64'(lits[k].v));
                    if (lits[k].cd) begin
                        chk($sformatf("lit data d%0d c%0d", lits[k].d, cyc), gd[lits[k].d], lits[k].data);
                        chk($sformatf("lit ovf d%0d c%0d", lits[k].d, cyc), 64'(go[lits[k].d]), 64'(lits[k].o));
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    initial begin : main
        int t;
        logic [63:0] rnd;
        bit r, v, l;

        // Reset state visible in the first cycle after release.
        add_lit(0, 3, 1'b0, 64'h0, 1'b0, 1'b1);
        add_lit(5, 3, 1'b0, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 36'h0);

        // Single beat of all -8: -72, exactly LAT=6 cycles later.
        t = cyc;
        add_lit(0, t + 5, 1'b0, 64'h0, 1'b0, 1'b0);
        add_lit(0, t + 6, 1'b1, 64'hFFB8, 1'b0, 1'b1);
        add_lit(0, t + 7, 1'b0, 64'h0, 1'b0, 1'b0);
        add_lit(4, t + 2, 1'b1, 64'h38, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 36'h888888888);
        idle(8);

        // Three beats of all 7 with an idle gap mid-pixel: 189 / clamp / wrap.
        step(1'b0, 1'b1, 1'b0, 36'h777777777);
        step(1'b0, 1'b1, 1'b0, 36'h777777777);
        idle(2);
        t = cyc;
        add_lit(0, t + 5, 1'b0, 64'h0, 1'b0, 1'b0);
        add_lit(0, t + 6, 1'b1, 64'h00BD, 1'b0, 1'b1);
        add_lit(1, t + 6, 1'b1, 64'h7F, 1'b1, 1'b1);
        add_lit(2, t + 6, 1'b1, 64'hBD, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 36'h777777777);
        idle(8);

        // Back-to-back single-beat pixels.
        t = cyc;
        add_lit(0, t + 6, 1'b1, 64'd9, 1'b0, 1'b1);
        add_lit(0, t + 7, 1'b1, 64'd18, 1'b0, 1'b1);
        add_lit(0, t + 8, 1'b1, 64'd27, 1'b0, 1'b1);
        add_lit(0, t + 9, 1'b0, 64'd27, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 36'h111111111);
        step(1'b0, 1'b1, 1'b1, 36'h222222222);
        step(1'b0, 1'b1, 1'b1, 36'h333333333);
        idle(8);

        // Unsigned all-15 single beat.
        t = cyc;
        add_lit(3, t + 6, 1'b1, 64'd135, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 36'hFFFFFFFFF);
        idle(8);

        // Reset while a two-beat pixel is in flight, then a fresh pixel.
        t = cyc;
        add_lit(0, t + 4, 1'b0, 64'h0, 1'b0, 1'b1);
        add_lit(0, t + 7, 1'b0, 64'h0, 1'b0, 1'b0);
        add_lit(0, t + 10, 1'b1, 64'd9, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 36'h222222222);
        step(1'b0, 1'b1, 1'b1, 36'h222222222);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 36'h0);
        step(1'b0, 1'b1, 1'b1, 36'h111111111);
        idle(8);

        // Random traffic, including in_last without in_valid and rare resets.
        for (int i = 0; i < 1500; i++) begin
            rnd = {$urandom(), $urandom()};
            r = ($urandom_range(0, 299) == 0);
            v = !r && ($urandom_range(0, 9) < 6);
            l = ($urandom_range(0, 9) < 3);
            step(r, v, l, rnd[35:0]);
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
